// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester/response channel of the ALU arbiter.
//   req_valid / req_ready : operation handshake (requester -> arbiter)
//   a, b, ctrl            : operands and 4-bit ALU control
//   rsp_valid / rsp_ready : response handshake (arbiter -> consumer)
//   rsp_result, rsp_zero  : captured ALU result and zero flag
// master = client side (requester + consumer), slave = arbiter side.
interface alu_arbiter_if #(
  parameter int W = 64
) ();
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   ctrl;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;

  modport master (
    output req_valid, a, b, ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, a, b, ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter time-sharing one external
// combinational ALU. At most one request is granted per cycle; the ALU
// result and zero flag are captured into the granted requester's response
// register, visible the cycle after acceptance.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   ch0, ch1            : requester/response channels (alu_arbiter_if.slave)
//   alu_a, alu_b        : shared ALU operands (0 when nothing is granted)
//   alu_ctrl            : shared ALU control (0000 when nothing is granted)
//   alu_result, alu_zero: shared ALU outputs, combinational from alu_*
module alu_arbiter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave ch0,
  alu_arbiter_if.slave ch1,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero
);

  logic         prio;
  logic         vld0_p1;
  logic         vld1_p1;
  logic [W-1:0] result0_p1;
  logic [W-1:0] result1_p1;
  logic         zero0_p1;
  logic         zero1_p1;

  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

  // ---- stage p0: eligibility, grant and ALU drive (combinational) ----
  // A slot can take a new result when empty or being drained this cycle.
  // Readiness depends only on handshake inputs and state, never on the ALU.
  assign elig0 = ch0.req_valid & (~vld0_p1 | ch0.rsp_ready);
  assign elig1 = ch1.req_valid & (~vld1_p1 | ch1.rsp_ready);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    // Gating with reset keeps ready and the ALU bus quiet while in reset.
    if (reset) begin
      if (elig0 && elig1) begin
        grant0 = ~prio;
        grant1 = prio;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign ch0.req_ready = grant0;
  assign ch1.req_ready = grant1;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = 4'b0000;
    if (grant0) begin
      alu_a    = ch0.a;
      alu_b    = ch0.b;
      alu_ctrl = ch0.ctrl;
    end else if (grant1) begin
      alu_a    = ch1.a;
      alu_b    = ch1.b;
      alu_ctrl = ch1.ctrl;
    end
  end

  // ---- stage p1: response registers and priority pointer ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio    <= 1'b0;
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
    end else begin
      if (grant0)      prio <= 1'b1;
      else if (grant1) prio <= 1'b0;

      // A refill takes precedence over a drain, so no bubble appears.
      if (grant0)             vld0_p1 <= 1'b1;
      else if (ch0.rsp_ready) vld0_p1 <= 1'b0;

      if (grant1)             vld1_p1 <= 1'b1;
      else if (ch1.rsp_ready) vld1_p1 <= 1'b0;
    end
  end

  // Result/zero registers clear on reset and otherwise only load on a
  // grant; after a drain they keep the stale value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result0_p1 <= '0;
      zero0_p1   <= 1'b0;
      result1_p1 <= '0;
      zero1_p1   <= 1'b0;
    end else begin
      if (grant0) begin
        result0_p1 <= alu_result;
        zero0_p1   <= alu_zero;
      end
      if (grant1) begin
        result1_p1 <= alu_result;
        zero1_p1   <= alu_zero;
      end
    end
  end

  assign ch0.rsp_valid  = vld0_p1;
  assign ch0.rsp_result = result0_p1;
  assign ch0.rsp_zero   = zero0_p1;
  assign ch1.rsp_valid  = vld1_p1;
  assign ch1.rsp_result = result1_p1;
  assign ch1.rsp_zero   = zero1_p1;

endmodule
